cpu_ask2_soe_pulser: RTL and testbench

Avalon-MM slave that generates programmable trains of active-low strobe pulses on the ASK2 nSOE control line and senses the line level back. It sits directly downstream of the Nios CPU bus and drives the pin that the res_nSOE PIO overrides or senses. Software writes pulse width, gap and count, then starts a train; completion is reported by status and an optional interrupt.

---
 rtl/cpu_ask2_soe_pkg.sv | 16 +
 rtl/cpu_ask2_sync2.sv | 26 ++
 rtl/cpu_ask2_soe_pulser.sv | 151 +++++++++++++++
 tb/tb_cpu_ask2_soe_pulser.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ask2_soe_pkg.sv
// Shared definitions for the ASK2 nSOE strobe pulser: register map, CTRL bits, FSM states.
package cpu_ask2_soe_pkg;

    localparam logic [1:0] AddrCtrl  = 2'd0;
    localparam logic [1:0] AddrWidth = 2'd1;
    localparam logic [1:0] AddrGap   = 2'd2;
    localparam logic [1:0] AddrCount = 2'd3;

    localparam int unsigned CtrlStart   = 0;
    localparam int unsigned CtrlDoneClr = 1;
    localparam int unsigned CtrlIrqEn   = 2;
    localparam int unsigned CtrlAbort   = 3;

    typedef enum logic [1:0] {IDLE, LOW, GAP} state_e;

endpackage

// File: rtl/cpu_ask2_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to a programmable level.
module cpu_ask2_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cpu_ask2_soe_pulser.sv
// Avalon-MM slave producing programmable trains of active-low pulses on nSOE,
// with done/irq reporting and a synchronized read-back of the pin level.
module cpu_ask2_soe_pulser
    import cpu_ask2_soe_pkg::*;
#(
    parameter int unsigned WIDTH_W = 16,
    parameter int unsigned COUNT_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        soe_n,
    input  logic        soe_sense,
    output logic        irq
);

    logic [WIDTH_W-1:0] width_q, gap_q, phase_q;
    logic [COUNT_W-1:0] count_q, rem_q;
    logic               irq_en_q, done_q, start_q, soe_n_q;
    logic [31:0]        readdata_q, readdata_d;
    state_e             state_q;
    logic               sense_sync, busy;
    logic               wr_en, wr_ctrl, start_w, abort_w, clr_w;
    logic               unused_wdata;

    // Phase counter runs down to zero, so a phase of N cycles loads N-1; 0 acts as 1.
    function automatic logic [WIDTH_W-1:0] phase_len(input logic [WIDTH_W-1:0] v);
        return (v == '0) ? '0 : v - WIDTH_W'(1);
    endfunction

    assign wr_en        = chipselect & ~write_n;
    assign wr_ctrl      = wr_en & (address == AddrCtrl);
    assign abort_w      = wr_ctrl & writedata[CtrlAbort];
    assign start_w      = wr_ctrl & writedata[CtrlStart] & ~writedata[CtrlAbort];
    assign clr_w        = wr_ctrl & writedata[CtrlDoneClr];
    assign busy         = start_q | (state_q != IDLE);
    assign unused_wdata = ^writedata[31:WIDTH_W];

    cpu_ask2_sync2 #(
        .ResetVal (1'b1)
    ) u_sense_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (soe_sense),
        .q_o    (sense_sync)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_q    <= WIDTH_W'(1);
            gap_q      <= WIDTH_W'(1);
            count_q    <= '0;
            irq_en_q   <= 1'b0;
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
            if (wr_en) begin
                unique case (address)
                    AddrCtrl:  irq_en_q <= writedata[CtrlIrqEn];
                    AddrWidth: width_q  <= writedata[WIDTH_W-1:0];
                    AddrGap:   gap_q    <= writedata[WIDTH_W-1:0];
                    AddrCount: count_q  <= writedata[COUNT_W-1:0];
                endcase
            end
        end
    end

    // START is captured into start_q and acted on one edge later; ABORT acts at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            start_q <= 1'b0;
            soe_n_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            if (clr_w) done_q <= 1'b0;
            if (abort_w) begin
                state_q <= IDLE;
                soe_n_q <= 1'b1;
                rem_q   <= '0;
                start_q <= 1'b0;
            end else begin
                if (start_w && !busy) start_q <= 1'b1;
                unique case (state_q)
                    IDLE: begin
                        if (start_q) begin
                            start_q <= 1'b0;
                            if (count_q == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= LOW;
                                soe_n_q <= 1'b0;
                                phase_q <= phase_len(width_q);
                                rem_q   <= count_q;
                            end
                        end
                    end
                    LOW: begin
                        if (phase_q == '0) begin
                            rem_q   <= rem_q - COUNT_W'(1);
                            soe_n_q <= 1'b1;
                            if (rem_q == COUNT_W'(1)) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= GAP;
                                phase_q <= phase_len(gap_q);
                            end
                        end else begin
                            phase_q <= phase_q - WIDTH_W'(1);
                        end
                    end
                    GAP: begin
                        if (phase_q == '0) begin
                            state_q <= LOW;
                            soe_n_q <= 1'b0;
                            phase_q <= phase_len(width_q);
                        end else begin
                            phase_q <= phase_q - WIDTH_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        soe_n_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            AddrCtrl:  readdata_d = {28'b0, sense_sync, irq_en_q, done_q, busy};
            AddrWidth: readdata_d = 32'(width_q);
            AddrGap:   readdata_d = 32'(gap_q);
            AddrCount: readdata_d = 32'(rem_q);
        endcase
    end

    assign readdata = readdata_q;
    assign soe_n    = soe_n_q;
    assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_cpu_ask2_soe_pulser.sv
// Self-checking bench for cpu_ask2_soe_pulser: scoreboarded pin sequences and register reads.
module tb_cpu_ask2_soe_pulser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        soe_n;
    logic        soe_sense;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    // Expected {irq, soe_n} after each edge, starting with the START edge itself.
    localparam logic [1:0] Seq1 [10] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0,
                                         2'd1};
    localparam logic [1:0] Seq2 [7]  = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd3};
    localparam logic [1:0] SeqB [7]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};

    cpu_ask2_soe_pulser #(
        .WIDTH_W (16),
        .COUNT_W (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .soe_n      (soe_n),
        .soe_sense  (soe_sense),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL sb_underflow: got 0x%0h, expected an entry", obs);
        end else begin
            check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // Compare {irq, soe_n} at this negedge, then advance one cycle; n times.
    task automatic run_pins(input int n);
        repeat (n) begin
            pop_check({30'b0, irq, soe_n});
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        push_exp(tag, exp);
        address = a;
        @(negedge clk);
        pop_check(readdata);
    endtask

    task automatic sense_lag(input string tag, input logic lvl);
        int n;
        n = 7;
        address   = 2'd0;
        soe_sense = lvl;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (readdata[3] == lvl) begin
                n = i;
                break;
            end
        end
        check_eq(tag, 32'(n), 32'd3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        soe_sense  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_soe", {31'b0, soe_n}, 32'd1);
        check_eq("rst_rdata", readdata, 32'd0);
        check_eq("rst_irq", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        rd("rst_status", 2'd0, 32'h8);
        rd("rst_width", 2'd1, 32'd1);
        rd("rst_gap", 2'd2, 32'd1);
        rd("rst_count", 2'd3, 32'd0);

        // Basic train: WIDTH=3, GAP=2, COUNT=2.
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd2);
        wr(2'd3, 32'd2);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 10; i++) push_exp("t1_pins", 32'(Seq1[i]));
        run_pins(10);
        rd("t1_status", 2'd0, 32'hA);
        rd("t1_width", 2'd1, 32'd3);
        check_eq("t1_irq", {31'b0, irq}, 32'd0);
        wr(2'd0, 32'h2);

        // Zero WIDTH/GAP behave as one cycle; irq enabled.
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd0);
        wr(2'd3, 32'd3);
        check_eq("t2_irq_pre", {31'b0, irq}, 32'd0);
        wr(2'd0, 32'h5);
        for (int i = 0; i < 7; i++) push_exp("t2_pins", 32'(Seq2[i]));
        run_pins(7);
        check_eq("t2_irq_held", {31'b0, irq}, 32'd1);
        rd("t2_width", 2'd1, 32'd0);
        wr(2'd0, 32'h6);
        check_eq("t2_irq_clr", {31'b0, irq}, 32'd0);
        rd("t2_status", 2'd0, 32'hC);

        // COUNT=0: no pulse, done right away.
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 4; i++) push_exp("t3_pins", 32'd1);
        run_pins(4);
        rd("t3_status", 2'd0, 32'hA);

        // START during the gap must not queue a second train.
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd1);
        wr(2'd3, 32'd2);
        wr(2'd0, 32'h1);
        push_exp("tb_pins", 32'd1);
        push_exp("tb_pins", 32'd0);
        push_exp("tb_pins", 32'd0);
        run_pins(3);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 7; i++) push_exp("tb_pins2", 32'(SeqB[i]));
        run_pins(7);
        rd("tb_count", 2'd3, 32'd0);
        rd("tb_status", 2'd0, 32'hA);
        wr(2'd0, 32'h2);

        // ABORT during the second pulse.
        wr(2'd1, 32'd10);
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd5);
        wr(2'd0, 32'h1);
        repeat (15) @(negedge clk);
        check_eq("ab_low", {31'b0, soe_n}, 32'd0);
        rd("ab_rem", 2'd3, 32'd4);
        wr(2'd0, 32'h8);
        push_exp("ab_pins", 32'd1);
        run_pins(1);
        rd("ab_status", 2'd0, 32'h8);
        rd("ab_count", 2'd3, 32'd0);

        // START with ABORT in the same write never starts.
        wr(2'd0, 32'h9);
        for (int i = 0; i < 4; i++) push_exp("sa_pins", 32'd1);
        run_pins(4);
        rd("sa_status", 2'd0, 32'h8);

        sense_lag("sense_fall", 1'b0);
        sense_lag("sense_rise", 1'b1);

        // Reset in the middle of a LOW phase.
        wr(2'd1, 32'd10);
        wr(2'd3, 32'd2);
        wr(2'd0, 32'h5);
        repeat (3) @(negedge clk);
        check_eq("mr_low", {31'b0, soe_n}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mr_soe", {31'b0, soe_n}, 32'd1);
        check_eq("mr_rdata", readdata, 32'd0);
        check_eq("mr_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd("mr_status", 2'd0, 32'h8);
        rd("mr_width", 2'd1, 32'd1);
        rd("mr_gap", 2'd2, 32'd1);
        rd("mr_count", 2'd3, 32'd0);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 3; i++) push_exp("mr_pins", 32'd1);
        run_pins(3);
        rd("mr_done", 2'd0, 32'hA);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL sb_leftover: got %0d entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
